// File: rtl/keys_pkg.sv
// Shared constants and FSM encoding for the SPI key-readout frame controller.
//   NUM_KEYS_DEF  default number of keys (and 8-bit slots per frame)
//   IDX_W_DEF     key index width for the default key count
//   BITS_PER_KEY  bits shifted per key slot
//   BIT_W         width of the in-slot bit position
//   state_t       frame FSM states
package keys_pkg;

  localparam int NUM_KEYS_DEF = 89;
  localparam int IDX_W_DEF    = $clog2(NUM_KEYS_DEF);
  localparam int BITS_PER_KEY = 8;
  localparam int BIT_W        = $clog2(BITS_PER_KEY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/keys_spi_sched_if.sv
// Signal bundle between the SPI pins / key matrix and the frame controller.
//   spi_cs_g_i, spi_clk_g_i  raw SPI chip select (active low) and clock
//   keys_i_g                 live key states
//   snap_keys_o..irq_o       snapshot, sequencing and status outputs
// Modports: slave = frame controller, master = the side driving the pins.
interface keys_spi_sched_if
  import keys_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF,
  parameter int IDX_W    = $clog2(NUM_KEYS)
);

  logic                spi_cs_g_i;
  logic                spi_clk_g_i;
  logic [NUM_KEYS-1:0] keys_i_g;
  logic [NUM_KEYS-1:0] snap_keys_o;
  logic                snap_valid_o;
  logic [IDX_W-1:0]    key_idx_o;
  logic [BIT_W-1:0]    bit_idx_o;
  logic                bit_strobe_o;
  logic                frame_done_o;
  logic                abort_o;
  logic                overrun_o;
  logic                irq_o;

  modport slave (
    input  spi_cs_g_i, spi_clk_g_i, keys_i_g,
    output snap_keys_o, snap_valid_o, key_idx_o, bit_idx_o,
           bit_strobe_o, frame_done_o, abort_o, overrun_o, irq_o
  );

  modport master (
    output spi_cs_g_i, spi_clk_g_i, keys_i_g,
    input  snap_keys_o, snap_valid_o, key_idx_o, bit_idx_o,
           bit_strobe_o, frame_done_o, abort_o, overrun_o, irq_o
  );

endinterface

// File: rtl/keys_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a history
// flop for edge detection.
//   clk_g_i, rst_g_i  system clock, async active-high reset
//   d_i               raw asynchronous input
//   rise_o, fall_o    one-cycle pulses on a synchronised edge
// The chain resets to RST_VAL. Edges are suppressed until the raw value has
// had time to reach the history flop, so a pin sitting at the opposite level
// across reset release is never reported as an edge.
module keys_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk_g_i,
  input  logic rst_g_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   primed;
  logic                   lvl;

  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q  <= sync_q[SYNC_STAGES-1];
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign lvl    = sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES];
  assign rise_o = primed &  lvl & ~hist_q;
  assign fall_o = primed & ~lvl &  hist_q;

endmodule

// File: rtl/keys_spi_sched.sv
// Frame controller in front of the SPI key-readout datapath.
//   clk_g_i  system clock (rising edge)
//   rst_g_i  asynchronous active-high reset
//   bus      keys_spi_sched_if.slave: raw SPI cs/sclk and live keys in;
//            key snapshot, slot/bit sequencing, frame status and the
//            debounced key-change interrupt out.
// A synced cs fall captures the keys; each synced sclk rise then steps the
// bit/slot position until the last bit of the last slot. Every output is
// registered.
module keys_spi_sched
  import keys_pkg::*;
#(
  parameter int NUM_KEYS    = NUM_KEYS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_HOLDOFF = 16,
  parameter int IDX_W       = $clog2(NUM_KEYS)
) (
  input  logic             clk_g_i,
  input  logic             rst_g_i,
  keys_spi_sched_if.slave  bus
);

  localparam int               HOLD_W   = $clog2(IRQ_HOLDOFF + 1);
  localparam logic [IDX_W-1:0] LAST_KEY = IDX_W'(NUM_KEYS - 1);
  localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(BITS_PER_KEY - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(IRQ_HOLDOFF);

  // Holdoff counter step: saturates at IRQ_HOLDOFF, clears when keys match.
  function automatic logic [HOLD_W-1:0] hold_next(input logic [HOLD_W-1:0] cnt,
                                                  input logic              diff);
    if (!diff)               return '0;
    else if (cnt == HOLD_MAX) return cnt;
    else                      return cnt + 1'b1;
  endfunction

  logic cs_rise, cs_fall, sclk_rise, sclk_fall_unused;

  keys_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_g_i (clk_g_i),
    .rst_g_i (rst_g_i),
    .d_i     (bus.spi_cs_g_i),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  keys_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_g_i (clk_g_i),
    .rst_g_i (rst_g_i),
    .d_i     (bus.spi_clk_g_i),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall_unused)
  );

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic                vld_q, vld_d;
  logic [IDX_W-1:0]    key_q, key_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                strobe_q, strobe_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                ovr_q, ovr_d;
  logic                irq_q, irq_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                diff;

  assign diff = (bus.keys_i_g != snap_q);

  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      state_q  <= ST_IDLE;
      snap_q   <= '0;
      vld_q    <= 1'b0;
      key_q    <= '0;
      bit_q    <= TOP_BIT;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      vld_q    <= vld_d;
      key_q    <= key_d;
      bit_q    <= bit_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    vld_d    = vld_q;
    key_d    = key_q;
    bit_d    = bit_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    ovr_d    = ovr_q;
    irq_d    = irq_q;
    hold_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        hold_d = hold_next(hold_q, diff);
        if (hold_d == HOLD_MAX) irq_d = 1'b1;
        if (cs_fall) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        snap_d  = bus.keys_i_g;
        vld_d   = 1'b1;
        key_d   = '0;
        bit_d   = TOP_BIT;
        ovr_d   = 1'b0;
        irq_d   = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // cs rise takes priority over a coincident sclk rise.
        if (cs_rise) begin
          abort_d = 1'b1;
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          strobe_d = 1'b1;
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
          end else if (key_q == LAST_KEY) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            bit_d = TOP_BIT;
            key_d = key_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        vld_d  = 1'b0;
        hold_d = hold_next(hold_q, diff);
        if (hold_d == HOLD_MAX) irq_d = 1'b1;
        if (sclk_rise) ovr_d = 1'b1;
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.snap_keys_o  = snap_q;
  assign bus.snap_valid_o = vld_q;
  assign bus.key_idx_o    = key_q;
  assign bus.bit_idx_o    = bit_q;
  assign bus.bit_strobe_o = strobe_q;
  assign bus.frame_done_o = done_q;
  assign bus.abort_o      = abort_q;
  assign bus.overrun_o    = ovr_q;
  assign bus.irq_o        = irq_q;

endmodule

// File: tb/tb_keys_spi_sched.sv
// Bench for keys_spi_sched: the stimulus side keeps a frame-level model
// (bits accepted, snapshot, overrun) and queues the strobe/done/abort events
// it expects; a monitor pops and compares each event the DUT presents.
module tb_keys_spi_sched;
  import keys_pkg::*;

  localparam int NK    = 89;
  localparam int TOTAL = NK * BITS_PER_KEY;

  typedef struct {
    bit          strobe;
    bit          done;
    bit          abort;
    int          key;
    int          bitp;
    bit          chk_bit;
    logic [NK-1:0] snap;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keys_spi_sched_if #(.NUM_KEYS(NK)) bus ();

  keys_spi_sched #(.NUM_KEYS(NK), .SYNC_STAGES(2), .IRQ_HOLDOFF(16)) dut (
    .clk_g_i (clk),
    .rst_g_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  evt_t exp_q[$];
  evt_t mon_e;
  int cyc = 0;
  int done_cyc = -1;
  int irq_rise_cyc = -1;
  int done_cnt = 0;
  logic irq_prev = 1'b0;

  bit            in_frame = 0;
  int            nbits = 0;
  bit            exp_ovr = 0;
  logic [NK-1:0] model_snap = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic evt_t mk(bit s, bit d, bit a, int n);
    evt_t e;
    e.strobe = s; e.done = d; e.abort = a; e.snap = model_snap;
    if (n < TOTAL) begin
      e.key = n / BITS_PER_KEY; e.bitp = 7 - (n % BITS_PER_KEY); e.chk_bit = 1;
    end else begin
      e.key = NK - 1; e.bitp = 0; e.chk_bit = 0;
    end
    return e;
  endfunction

  function automatic logic [NK-1:0] rnd_keys();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NK-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.irq_o && !irq_prev) irq_rise_cyc = cyc;
    irq_prev = bus.irq_o;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && (bus.bit_strobe_o || bus.frame_done_o || bus.abort_o)) begin
      if (bus.frame_done_o) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 128'({bus.bit_strobe_o, bus.frame_done_o, bus.abort_o}), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_flags", 128'({bus.bit_strobe_o, bus.frame_done_o, bus.abort_o}),
            128'({mon_e.strobe, mon_e.done, mon_e.abort}));
        chk("event_key_idx", 128'(bus.key_idx_o), 128'(mon_e.key));
        if (mon_e.chk_bit) chk("event_bit_idx", 128'(bus.bit_idx_o), 128'(mon_e.bitp));
        chk("event_snap", 128'(bus.snap_keys_o), 128'(mon_e.snap));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_pulse();
    if (in_frame) begin
      nbits++;
      if (nbits <= TOTAL) exp_q.push_back(mk(1, nbits == TOTAL, 0, nbits));
      else exp_ovr = 1;
    end
    @(negedge clk); bus.spi_clk_g_i = 1'b1;
    tick(4);        bus.spi_clk_g_i = 1'b0;
    tick(3);
  endtask

  task automatic cs_low();
    @(negedge clk); bus.spi_cs_g_i = 1'b0;
    model_snap = bus.keys_i_g; in_frame = 1; nbits = 0; exp_ovr = 0;
    tick(7);
  endtask

  task automatic cs_high();
    if (in_frame && nbits < TOTAL) exp_q.push_back(mk(0, 0, 1, nbits));
    in_frame = 0;
    @(negedge clk); bus.spi_cs_g_i = 1'b1;
    tick(7);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_snap"},   128'(bus.snap_keys_o),  128'(0));
    chk({tag, "_valid"},  128'(bus.snap_valid_o), 128'(0));
    chk({tag, "_key"},    128'(bus.key_idx_o),    128'(0));
    chk({tag, "_bit"},    128'(bus.bit_idx_o),    128'(7));
    chk({tag, "_strobe"}, 128'(bus.bit_strobe_o), 128'(0));
    chk({tag, "_done"},   128'(bus.frame_done_o), 128'(0));
    chk({tag, "_abort"},  128'(bus.abort_o),      128'(0));
    chk({tag, "_ovr"},    128'(bus.overrun_o),    128'(0));
    chk({tag, "_irq"},    128'(bus.irq_o),        128'(0));
  endtask

  task automatic check_frame_start(input string tag);
    chk({tag, "_valid"}, 128'(bus.snap_valid_o), 128'(1));
    chk({tag, "_snap"},  128'(bus.snap_keys_o),  128'(model_snap));
    chk({tag, "_key"},   128'(bus.key_idx_o),    128'(0));
    chk({tag, "_bit"},   128'(bus.bit_idx_o),    128'(7));
    chk({tag, "_ovr"},   128'(bus.overrun_o),    128'(0));
    chk({tag, "_irq"},   128'(bus.irq_o),        128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NK-1:0] k;
    bus.spi_cs_g_i  = 1'b1;
    bus.spi_clk_g_i = 1'b0;
    bus.keys_i_g    = '0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(10);

    // Full frame with fixed keys; keys change after strobe 10.
    bus.keys_i_g = 89'h1_2345_6789_ABCD_EF01_2345;
    cs_low();
    check_frame_start("f1_start");
    irq_rise_cyc = -1;
    for (int i = 1; i <= TOTAL; i++) begin
      if (i == 11) bus.keys_i_g = '1;
      spi_pulse();
    end
    chk("f1_valid_dropped", 128'(bus.snap_valid_o), 128'(0));
    chk("f1_last_key", 128'(bus.key_idx_o), 128'(NK - 1));
    chk("f1_snap_frozen", 128'(bus.snap_keys_o), 128'(89'h1_2345_6789_ABCD_EF01_2345));
    tick(30);
    chk("f1_irq_latency", 128'(irq_rise_cyc - done_cyc), 128'(16));
    cs_high();

    // Mid-frame abort, then debounce boundary in IDLE.
    bus.keys_i_g = rnd_keys();
    cs_low();
    for (int i = 0; i < 100; i++) spi_pulse();
    cs_high();
    chk("abort_valid", 128'(bus.snap_valid_o), 128'(0));
    chk("abort_snap_kept", 128'(bus.snap_keys_o), 128'(model_snap));
    k = bus.keys_i_g;
    @(negedge clk); bus.keys_i_g = ~k;
    tick(15);       bus.keys_i_g = k;
    tick(20);
    chk("glitch15_no_irq", 128'(bus.irq_o), 128'(0));
    @(negedge clk); bus.keys_i_g = ~k;
    tick(16);       bus.keys_i_g = k;
    tick(2);
    chk("holdoff16_irq", 128'(bus.irq_o), 128'(1));
    cs_low();
    check_frame_start("restart");
    for (int i = 0; i < 20; i++) spi_pulse();

    // Coincident cs rise and sclk rise: abort wins.
    exp_q.push_back(mk(0, 0, 1, nbits));
    in_frame = 0;
    @(negedge clk); bus.spi_cs_g_i = 1'b1; bus.spi_clk_g_i = 1'b1;
    tick(4);        bus.spi_clk_g_i = 1'b0;
    tick(4);
    chk("tie_key_held", 128'(bus.key_idx_o), 128'(nbits / 8));
    chk("tie_bit_held", 128'(bus.bit_idx_o), 128'(7 - nbits % 8));

    // Overrun: three extra pulses past the end of frame.
    bus.keys_i_g = rnd_keys();
    cs_low();
    for (int i = 1; i <= TOTAL + 3; i++) begin
      spi_pulse();
      if (i == TOTAL)     chk("ovr_at_712", 128'(bus.overrun_o), 128'(exp_ovr));
      if (i == TOTAL + 1) chk("ovr_at_713", 128'(bus.overrun_o), 128'(exp_ovr));
    end
    chk("ovr_sticky", 128'(bus.overrun_o), 128'(1));
    cs_high();
    cs_low();
    chk("ovr_cleared", 128'(bus.overrun_o), 128'(0));

    // Asynchronous reset mid-SHIFT with cs held low.
    for (int i = 0; i < 5; i++) spi_pulse();
    @(posedge clk); #2; rst = 1'b1; #1;
    check_reset_vals("async_rst");
    in_frame = 0;
    @(negedge clk); rst = 1'b0;
    tick(30);
    chk("no_capture_after_rst", 128'(bus.snap_valid_o), 128'(0));
    spi_pulse();
    cs_high();
    bus.keys_i_g = rnd_keys();
    cs_low();
    check_frame_start("post_rst_capture");
    for (int i = 0; i < 3; i++) spi_pulse();
    cs_high();

    tick(10);
    chk("frame_done_count", 128'(done_cnt), 128'(2));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
